// File: rtl/rab_axi_pkg.sv
// rab_axi_pkg: shared AXI response codes and B-channel arbitration types for the RAB.
package rab_axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {UNLOCKED, LOCK_INJ, LOCK_FWD} lock_e;
  typedef enum logic {SRC_FWD, SRC_INJ} src_e;
endpackage

// File: rtl/rab_sync_fifo.sv
// rab_sync_fifo: single-clock FIFO, no push bypass when full, synchronous active-high reset.
module rab_sync_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  // extra pointer bit tells full from empty when the indices coincide
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/axi4_b_drop_sender.sv
// axi4_b_drop_sender: merges forwarded B responses with injected responses for dropped writes.
module axi4_b_drop_sender
  import rab_axi_pkg::*;
#(
  parameter int AXI_ID_WIDTH    = 10,
  parameter int AXI_USER_WIDTH  = 4,
  parameter int DROP_FIFO_DEPTH = 4,
  parameter int ARB_MODE        = 0,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arst,
  input  logic                      trans_drop,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id,
  input  logic [1:0]                trans_resp,
  output logic                      drop_ready,
  output logic                      drop_overflow,
  input  logic                      w_drop,
  input  logic                      s_axi4_wvalid,
  input  logic                      s_axi4_wready,
  input  logic                      s_axi4_wlast,
  output logic [AXI_ID_WIDTH-1:0]   s_axi4_bid,
  output logic [1:0]                s_axi4_bresp,
  output logic [AXI_USER_WIDTH-1:0] s_axi4_buser,
  output logic                      s_axi4_bvalid,
  input  logic                      s_axi4_bready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi4_bid,
  input  logic [1:0]                m_axi4_bresp,
  input  logic [AXI_USER_WIDTH-1:0] m_axi4_buser,
  input  logic                      m_axi4_bvalid,
  output logic                      m_axi4_bready,
  output logic                      response_sent,
  output logic [CNT_WIDTH-1:0]      inj_count
);
  localparam int CW = $clog2(DROP_FIFO_DEPTH + 1);
  logic [CW-1:0] credit;
  logic [AXI_ID_WIDTH+1:0] head;
  logic full, empty, inj_req, inj_hs, fwd_hs, w_done;
  lock_e state, state_nxt;
  src_e sel, last_grant;
  rab_sync_fifo #(.DATA_WIDTH(AXI_ID_WIDTH + 2), .DEPTH(DROP_FIFO_DEPTH)) u_fifo (
    .clk(axi4_aclk), .rst(axi4_arst), .push(trans_drop), .pop(inj_hs),
    .din({trans_id, trans_resp}), .dout(head), .full(full), .empty(empty)
  );
  assign drop_ready = !full;
  assign inj_req    = !empty && credit != '0;
  assign w_done     = s_axi4_wvalid && s_axi4_wready && s_axi4_wlast && w_drop;
  // a locked source keeps the slave B channel until its handshake completes
  always_comb begin
    sel = state == LOCK_INJ ? SRC_INJ :
          state == LOCK_FWD ? SRC_FWD :
          ARB_MODE == 0 ? (inj_req ? SRC_INJ : SRC_FWD) :
          (inj_req && m_axi4_bvalid) ? (last_grant == SRC_FWD ? SRC_INJ : SRC_FWD) :
          inj_req ? SRC_INJ : SRC_FWD;
    state_nxt = state;
    if (s_axi4_bvalid) state_nxt = s_axi4_bready ? UNLOCKED : (sel == SRC_INJ ? LOCK_INJ : LOCK_FWD);
  end
  assign s_axi4_bvalid = sel == SRC_INJ ? inj_req : m_axi4_bvalid;
  assign s_axi4_bid    = sel == SRC_INJ ? head[AXI_ID_WIDTH+1:2] : m_axi4_bid;
  assign s_axi4_bresp  = sel == SRC_INJ ? head[1:0] : m_axi4_bresp;
  assign s_axi4_buser  = sel == SRC_INJ ? '0 : m_axi4_buser;
  assign m_axi4_bready = sel == SRC_FWD && m_axi4_bvalid && s_axi4_bready;
  assign inj_hs        = sel == SRC_INJ && inj_req && s_axi4_bready;
  assign fwd_hs        = m_axi4_bready;
  assign response_sent = inj_hs;
  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      state         <= UNLOCKED;
      last_grant    <= SRC_FWD;
      credit        <= '0;
      drop_overflow <= 1'b0;
      inj_count     <= '0;
    end else begin
      state <= state_nxt;
      if (inj_hs || fwd_hs) last_grant <= inj_hs ? SRC_INJ : SRC_FWD;
      if (w_done && !inj_hs && credit != CW'(DROP_FIFO_DEPTH)) credit <= credit + 1'b1;
      else if (inj_hs && !w_done) credit <= credit - 1'b1;
      if (trans_drop && full) drop_overflow <= 1'b1;
      if (inj_hs && inj_count != '1) inj_count <= inj_count + 1'b1;
    end
  end
endmodule
